pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//   Duty-cycle sequencer for a single free-running PWM channel. Accepts target
//   duty requests over a valid/ready handshake. Moves the live duty toward the
//   target either in one jump or in fixed-size steps, and only ever at a PWM
//   period boundary, so the output never glitches. Sits between the software
//   register bank and the PWM output pin, and owns the PWM counter/comparator.
// PARAMETERS
//   CBITS  17       width of the PWM counter and all duty values; period = 2**CBITS clk
//   STEP   4096     duty increment/decrement applied per period while ramping (>=1)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   req_valid   in   1      new target duty offered
//   req_duty    in   CBITS  target duty, in clk cycles high per period
//   req_ramp    in   1      sampled with the request: 1 = step toward target, 0 = jump
//   req_ready   out  1      controller can accept a request (IDLE only)
//   busy        out  1      a request is pending or a ramp is in progress
//   duty_cur    out  CBITS  duty currently applied to the comparator
//   period_wrap out  1      1-cycle pulse on the cycle cnt == 2**CBITS-1
//   pwm_out     out  1      registered PWM output: 1 while cnt < duty_cur
// BEHAVIOUR
//   Reset (async): cnt=0, duty_cur=0, pwm_out=0, period_wrap=0, state=IDLE,
//     req_ready=1, busy=0. The target and ramp-mode registers are cleared to 0.
//   Counter: cnt increments every clk and wraps to 0 modulo 2**CBITS.
//     The counter is never stalled or reloaded by requests.
//   pwm_out <= (cnt < duty_cur). This gives 1 cycle latency from cnt to the pin.
//     duty 0 gives constant 0. duty 2**CBITS-1 gives high for all but 1 cycle per period.
//   Handshake: a transfer happens when req_valid & req_ready. It captures
//     req_duty and req_ramp. Requests presented while not ready are ignored,
//     not queued. req_ready = (state==IDLE), so it is combinational from state.
//   FSM:
//     IDLE -> transfer -> WAIT_WRAP if req_ramp==0, else RAMP.
//     WAIT_WRAP: on period_wrap, duty_cur<=target, then -> IDLE.
//     RAMP: on each period_wrap, apply one step:
//       |target-duty_cur| <= STEP: duty_cur<=target, then -> IDLE.
//       target > duty_cur: duty_cur <= duty_cur + STEP.
//       otherwise: duty_cur <= duty_cur - STEP.
//       Use CBITS+1-bit arithmetic; the result never overshoots or wraps.
//   busy = (state != IDLE).
//   Update timing: duty_cur changes only on the cycle period_wrap is high.
//     The new value therefore first affects pwm_out on the first cycle of the
//     new period (cnt==0).
//   Request equal to duty_cur: still waits for one wrap, then returns to IDLE.
//     duty_cur does not change.
//   Request accepted in the same cycle as period_wrap: that wrap is not used.
//     The update waits for the next wrap.
//   Reset mid-ramp: everything returns to reset values immediately. The ramp is
//     abandoned, and pwm_out is 0 until a new request completes.
//   Liveness: from any accepted request, busy falls within
//     ceil(2**CBITS/STEP)+1 periods. pwm_out is eventually 0 whenever duty_cur < 2**CBITS-1.
// STRUCTURE
//   Shared package pwm_pkg:
//     typedef enum {IDLE, WAIT_WRAP, RAMP} pwm_ctrl_state_e
//     localparam CBITS_DEFAULT = 17
//   Sub-module pwm_core (CBITS): free-running counter, period_wrap generation,
//     and the registered comparator. Inputs are duty_cur; outputs are pwm_out and period_wrap.
//   pwm_ramp_ctrl contains the handshake, the FSM and the step arithmetic.
// TESTING  (CBITS=8, STEP=16, period=256 clk)
//   1. Ramp up: from reset, request duty=64, ramp=1.
//      Expect duty_cur 16,32,48,64 on 4 successive wraps. busy falls on the 4th wrap.
//      In period k, pwm_out is high for exactly duty_cur cycles.
//   2. Jump: request duty=200, ramp=0.
//      Expect duty_cur=200 at the next wrap. No intermediate values appear.
//      Expect 200 high cycles per period thereafter.
//   3. Ramp down, non-multiple step: with duty_cur=64, request duty=10, ramp=1.
//      Expect 48, 32, 16, 10. req_ready returns on the 4th wrap.
//   4. Request while busy: during test 1, drive req_valid with duty=255.
//      Expect req_ready=0. The request is ignored and the ramp still ends at 64.
//   5. Reset mid-ramp: assert rst asynchronously, mid-period, during the ramp to 64.
//      Expect outputs at reset values in the same cycle.
//      Expect pwm_out=0 for 3 full periods afterwards.
//   6. Extremes: duty=0 gives pwm_out constant 0. duty=255 gives exactly 1 low cycle
//      per period, at cnt==255. A request accepted on a period_wrap cycle updates
//      one wrap later.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and defaults for the PWM duty-cycle sequencer.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        RAMP      = 2'd2
    } pwm_ctrl_state_e;

    localparam int CBITS_DEFAULT = 17;
    localparam int STEP_DEFAULT  = 4096;

    function automatic logic state_is_busy(input pwm_ctrl_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Target-duty request channel: valid/ready handshake carrying duty and ramp mode.
interface pwm_ramp_ctrl_if
    import pwm_pkg::*;
#(
    parameter int CBITS = CBITS_DEFAULT
) ();

    logic             req_valid;
    logic [CBITS-1:0] req_duty;
    logic             req_ramp;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_duty,
        output req_ramp,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_duty,
        input  req_ramp,
        output req_ready
    );

endinterface

// File: rtl/pwm_ramp_ctrl_core.sv
// Free-running PWM counter, period-wrap pulse and registered comparator.
module pwm_core #(
    parameter int CBITS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] i_duty_cur,
    output logic             o_pwm_out,
    output logic             o_period_wrap
);

    logic [CBITS-1:0] r_cnt;
    logic             r_pwm_out;
    logic             w_wrap;

    // Counter is never stalled or reloaded; it simply wraps modulo 2**CBITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CBITS{1'b0}};
        end else begin
            r_cnt <= r_cnt + {{(CBITS-1){1'b0}}, 1'b1};
        end
    end

    // Comparator output is registered so the pin never sees combinational hazards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_out <= (r_cnt < i_duty_cur);
        end
    end

    assign w_wrap        = &r_cnt;
    assign o_period_wrap = w_wrap;
    assign o_pwm_out     = r_pwm_out;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: accepts target duties and moves the live duty toward
// them (jump or fixed steps), only ever at a PWM period boundary.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CBITS = CBITS_DEFAULT,
    parameter int STEP  = STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    pwm_ramp_ctrl_if.slave   req_if,
    output logic             o_busy,
    output logic [CBITS-1:0] o_duty_cur,
    output logic             o_period_wrap,
    output logic             o_pwm_out
);

    localparam logic [CBITS:0] STEP_X = (CBITS+1)'(STEP);

    pwm_ctrl_state_e  r_state;
    pwm_ctrl_state_e  w_state_nxt;
    logic [CBITS-1:0] r_target;
    logic [CBITS-1:0] w_target_nxt;
    logic             r_ramp;
    logic             w_ramp_nxt;
    logic [CBITS-1:0] r_duty_cur;
    logic [CBITS-1:0] w_duty_nxt;

    logic             w_xfer;
    logic             w_wrap;
    logic [CBITS:0]   w_cur_x;
    logic [CBITS:0]   w_tgt_x;
    logic [CBITS:0]   w_diff;
    logic [CBITS:0]   w_stepped;
    logic             w_up;
    logic             w_last_step;
    logic [CBITS-1:0] w_ramp_duty;

    assign w_xfer            = req_if.req_valid && (r_state == IDLE);
    assign req_if.req_ready  = (r_state == IDLE);
    assign o_busy            = state_is_busy(r_state);
    assign o_duty_cur        = r_duty_cur;
    assign o_period_wrap     = w_wrap;

    // One ramp step in CBITS+1 bits; a carry/borrow would mean overshoot, so clamp to target.
    always_comb begin
        w_cur_x = {1'b0, r_duty_cur};
        w_tgt_x = {1'b0, r_target};
        w_up    = (w_tgt_x > w_cur_x);
        if (w_up) begin
            w_diff    = w_tgt_x - w_cur_x;
            w_stepped = w_cur_x + STEP_X;
        end else begin
            w_diff    = w_cur_x - w_tgt_x;
            w_stepped = w_cur_x - STEP_X;
        end
        w_last_step = (w_diff <= STEP_X);
        if (w_last_step || w_stepped[CBITS]) begin
            w_ramp_duty = r_target;
        end else begin
            w_ramp_duty = w_stepped[CBITS-1:0];
        end
    end

    // Next-state and datapath updates; a wrap coincident with acceptance is not used.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_ramp_nxt   = r_ramp;
        w_duty_nxt   = r_duty_cur;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_target_nxt = req_if.req_duty;
                    w_ramp_nxt   = req_if.req_ramp;
                    w_state_nxt  = req_if.req_ramp ? RAMP : WAIT_WRAP;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            WAIT_WRAP: begin
                if (w_wrap) begin
                    w_duty_nxt  = r_target;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_WRAP;
                end
            end
            RAMP: begin
                if (w_wrap) begin
                    w_duty_nxt  = w_ramp_duty;
                    w_state_nxt = w_last_step ? IDLE : RAMP;
                end else begin
                    w_state_nxt = RAMP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target, mode and live duty registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target   <= {CBITS{1'b0}};
            r_ramp     <= 1'b0;
            r_duty_cur <= {CBITS{1'b0}};
        end else begin
            r_target   <= w_target_nxt;
            r_ramp     <= w_ramp_nxt;
            r_duty_cur <= w_duty_nxt;
        end
    end

    pwm_core #(
        .CBITS (CBITS)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .i_duty_cur    (r_duty_cur),
        .o_pwm_out     (o_pwm_out),
        .o_period_wrap (w_wrap)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl at CBITS=8, STEP=16 (256-cycle period).
module tb_pwm_ramp_ctrl;

    localparam int CB = 8;
    localparam int ST = 16;

    logic          clk;
    logic          rst;
    logic          busy;
    logic [CB-1:0] duty_cur;
    logic          period_wrap;
    logic          pwm_out;

    int n_checks;
    int n_pass;

    pwm_ramp_ctrl_if #(.CBITS(CB)) u_if ();

    pwm_ramp_ctrl #(
        .CBITS (CB),
        .STEP  (ST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_if        (u_if),
        .o_busy        (busy),
        .o_duty_cur    (duty_cur),
        .o_period_wrap (period_wrap),
        .o_pwm_out     (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one request at the current negedge; it transfers on the next posedge.
    task automatic send_req(input string tag, input int duty, input logic ramp);
        check({tag, "_ready"}, 32'(u_if.req_ready), 32'd1);
        u_if.req_valid = 1'b1;
        u_if.req_duty  = CB'(duty);
        u_if.req_ramp  = ramp;
        @(negedge clk);
        u_if.req_valid = 1'b0;
    endtask

    // Advance to the negedge with cnt==0 right after the next period_wrap.
    task automatic sync_wrap(input string tag);
        int k;
        k = 0;
        while (!period_wrap && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wrap_seen"}, 32'(k < 300), 32'd1);
        @(negedge clk);
    endtask

    // From a cnt==0 negedge, count pwm_out over one full period (cnt_prev 0..255).
    task automatic period_step(output int high, output int last_low);
        high     = 0;
        last_low = -1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) high++;
            else last_low = i;
        end
    endtask

    initial begin
        int h;
        int ll;
        int k;
        n_checks = 0;
        n_pass   = 0;
        rst            = 1'b1;
        u_if.req_valid = 1'b0;
        u_if.req_duty  = '0;
        u_if.req_ramp  = 1'b0;

        @(negedge clk);
        check("rst_duty",  32'(duty_cur),       32'd0);
        check("rst_busy",  32'(busy),           32'd0);
        check("rst_ready", 32'(u_if.req_ready), 32'd1);
        check("rst_pwm",   32'(pwm_out),        32'd0);
        check("rst_wrap",  32'(period_wrap),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Ramp up 0 -> 64, with a request offered while busy.
        send_req("up", 64, 1'b1);
        u_if.req_valid = 1'b1;
        u_if.req_duty  = 8'd255;
        u_if.req_ramp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_ready", 32'(u_if.req_ready), 32'd0);
            check("busy_busy",  32'(busy),           32'd1);
        end
        u_if.req_valid = 1'b0;
        sync_wrap("up1");
        check("up_d16", 32'(duty_cur), 32'd16);
        check("up_b1",  32'(busy),     32'd1);
        period_step(h, ll);
        check("up_h16", 32'(h),        32'd16);
        check("up_d32", 32'(duty_cur), 32'd32);
        check("up_b2",  32'(busy),     32'd1);
        period_step(h, ll);
        check("up_h32", 32'(h),        32'd32);
        check("up_d48", 32'(duty_cur), 32'd48);
        check("up_b3",  32'(busy),     32'd1);
        period_step(h, ll);
        check("up_h48", 32'(h),        32'd48);
        check("up_d64", 32'(duty_cur), 32'd64);
        check("up_b4",  32'(busy),     32'd0);
        check("up_rdy", 32'(u_if.req_ready), 32'd1);
        period_step(h, ll);
        check("up_h64", 32'(h),        32'd64);
        check("up_hold64", 32'(duty_cur), 32'd64);

        // Ramp down 64 -> 10 with a final short step.
        send_req("dn", 10, 1'b1);
        sync_wrap("dn1");
        check("dn_d48", 32'(duty_cur), 32'd48);
        check("dn_rdy1", 32'(u_if.req_ready), 32'd0);
        period_step(h, ll);
        check("dn_h48", 32'(h),        32'd48);
        check("dn_d32", 32'(duty_cur), 32'd32);
        period_step(h, ll);
        check("dn_h32", 32'(h),        32'd32);
        check("dn_d16", 32'(duty_cur), 32'd16);
        check("dn_rdy3", 32'(u_if.req_ready), 32'd0);
        period_step(h, ll);
        check("dn_h16", 32'(h),        32'd16);
        check("dn_d10", 32'(duty_cur), 32'd10);
        check("dn_rdy4", 32'(u_if.req_ready), 32'd1);
        period_step(h, ll);
        check("dn_h10", 32'(h),        32'd10);

        // Jump 10 -> 200.
        send_req("jmp", 200, 1'b0);
        check("jmp_wait", 32'(duty_cur), 32'd10);
        sync_wrap("jmp");
        check("jmp_d200", 32'(duty_cur), 32'd200);
        check("jmp_busy", 32'(busy),     32'd0);
        period_step(h, ll);
        check("jmp_h200", 32'(h),        32'd200);

        // Extremes: duty 0 and duty 255.
        send_req("z", 0, 1'b0);
        sync_wrap("z");
        check("z_d0", 32'(duty_cur), 32'd0);
        period_step(h, ll);
        check("z_h0", 32'(h), 32'd0);
        send_req("f", 255, 1'b0);
        sync_wrap("f");
        check("f_d255", 32'(duty_cur), 32'd255);
        period_step(h, ll);
        check("f_h255", 32'(h),  32'd255);
        check("f_low_at", 32'(ll), 32'd255);

        // Request accepted on the wrap cycle waits for the following wrap.
        k = 0;
        while (!period_wrap && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("ow_wrap_seen", 32'(k < 300), 32'd1);
        send_req("ow", 100, 1'b0);
        check("ow_busy",  32'(busy),     32'd1);
        check("ow_d255",  32'(duty_cur), 32'd255);
        period_step(h, ll);
        check("ow_h255",  32'(h),        32'd255);
        check("ow_d100",  32'(duty_cur), 32'd100);
        check("ow_done",  32'(busy),     32'd0);

        // Request equal to current duty still takes one wrap.
        send_req("eq", 100, 1'b0);
        check("eq_busy", 32'(busy), 32'd1);
        sync_wrap("eq");
        check("eq_d100", 32'(duty_cur), 32'd100);
        check("eq_done", 32'(busy),     32'd0);

        // Reset mid-ramp, mid-period, while pwm_out is high.
        send_req("rr", 64, 1'b1);
        sync_wrap("rr");
        check("rr_d84", 32'(duty_cur), 32'd84);
        repeat (40) @(negedge clk);
        check("rr_pwm_hi", 32'(pwm_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rr_duty",  32'(duty_cur),       32'd0);
        check("rr_busy",  32'(busy),           32'd0);
        check("rr_ready", 32'(u_if.req_ready), 32'd1);
        check("rr_pwm",   32'(pwm_out),        32'd0);
        check("rr_wrap",  32'(period_wrap),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        h = 0;
        for (int i = 0; i < 768; i++) begin
            @(negedge clk);
            if (pwm_out) h++;
        end
        check("rr_h0",    32'(h),        32'd0);
        check("rr_d0",    32'(duty_cur), 32'd0);
        check("rr_idle",  32'(busy),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
